// File: rtl/alu_operand_stage_if.sv
// Decode, hazard-unit, producer and ALU-side signals of the ID/EX operand stage.
// master: the surrounding pipeline; slave: alu_operand_stage.
interface alu_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [REGW-1:0] in_rs1;
  logic [REGW-1:0] in_rs2;
  logic [REGW-1:0] in_rd;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic            in_alu_src;
  logic [3:0]      in_alu_control;
  logic            in_reg_write;
  logic            stall;
  logic            flush;
  logic            exmem_reg_write;
  logic            memwb_reg_write;
  logic [REGW-1:0] exmem_rd;
  logic [REGW-1:0] memwb_rd;
  logic [XLEN-1:0] exmem_result;
  logic [XLEN-1:0] memwb_result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_control;
  logic            ex_valid;
  logic            ex_reg_write;
  logic [REGW-1:0] ex_rd;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
           in_alu_src, in_alu_control, in_reg_write, stall, flush,
           exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
           exmem_result, memwb_result,
    input  in_ready, alu_a, alu_b, alu_control, ex_valid, ex_reg_write,
           ex_rd, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
           in_alu_src, in_alu_control, in_reg_write, stall, flush,
           exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
           exmem_result, memwb_result,
    output in_ready, alu_a, alu_b, alu_control, ex_valid, ex_reg_write,
           ex_rd, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding the ALU.
// Forwarding, fwd_*_sel and stall refresh exist only when ALU_OPERAND_FWD_EN is defined.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input logic               clk,
  input logic               rst,
  alu_operand_stage_if.slave bus
);
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic [3:0]      alu_control;
    logic            reg_write;
  } stage_t;

  stage_t          stage_q, stage_d;
  fwd_sel_e        fwd_a, fwd_b;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

`ifdef ALU_OPERAND_FWD_EN
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (stage_q.valid) begin
      if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == stage_q.rs1)
        fwd_a = FWD_EXMEM;
      else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == stage_q.rs1)
        fwd_a = FWD_MEMWB;
      if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == stage_q.rs2)
        fwd_b = FWD_EXMEM;
      else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == stage_q.rs2)
        fwd_b = FWD_MEMWB;
    end
  end

  always_comb begin
    rs1_fwd = stage_q.rs1_data;
    rs2_fwd = stage_q.rs2_data;
    if (fwd_a == FWD_EXMEM)      rs1_fwd = bus.exmem_result;
    else if (fwd_a == FWD_MEMWB) rs1_fwd = bus.memwb_result;
    if (fwd_b == FWD_EXMEM)      rs2_fwd = bus.exmem_result;
    else if (fwd_b == FWD_MEMWB) rs2_fwd = bus.memwb_result;
  end
`else
  logic unused_fwd;

  assign fwd_a      = FWD_REG;
  assign fwd_b      = FWD_REG;
  assign rs1_fwd    = stage_q.rs1_data;
  assign rs2_fwd    = stage_q.rs2_data;
  assign unused_fwd = ^{bus.exmem_reg_write, bus.memwb_reg_write, bus.exmem_rd,
                        bus.memwb_rd, bus.exmem_result, bus.memwb_result};
`endif

  // Stall latches the forwarded operands; without forwarding these equal the held data.
  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      stage_d = '0;
    end else if (bus.stall) begin
      stage_d.rs1_data = rs1_fwd;
      stage_d.rs2_data = rs2_fwd;
    end else if (bus.in_valid) begin
      stage_d.valid       = 1'b1;
      stage_d.rs1         = bus.in_rs1;
      stage_d.rs2         = bus.in_rs2;
      stage_d.rd          = bus.in_rd;
      stage_d.rs1_data    = bus.in_rs1_data;
      stage_d.rs2_data    = bus.in_rs2_data;
      stage_d.imm         = bus.in_imm;
      stage_d.alu_src     = bus.in_alu_src;
      stage_d.alu_control = bus.in_alu_control;
      stage_d.reg_write   = bus.in_reg_write;
    end else begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign bus.in_ready     = ~bus.stall & ~bus.flush;
  assign bus.alu_a        = rs1_fwd;
  assign bus.alu_b        = stage_q.alu_src ? stage_q.imm : rs2_fwd;
  assign bus.alu_control  = stage_q.alu_control;
  assign bus.ex_valid     = stage_q.valid;
  assign bus.ex_reg_write = stage_q.reg_write;
  assign bus.ex_rd        = stage_q.rd;
  assign bus.fwd_a_sel    = fwd_a;
  assign bus.fwd_b_sel    = fwd_b;
endmodule
